// File: rtl/led_pattern_gen.sv
// led_pattern_gen: stepped LED pattern generator (rotate left/right, bounce, blink) at four speeds.
// Ports: clk, rst_n (async active-low), en (run enable), mode[1:0], speed[1:0]
//        (step period = DIV >> speed), step_o (one-cycle pulse per pattern advance),
//        LED[N_LED-1:0] (registered, active low).
// Define LED_PWM_DIM_EN to add a 4-bit duty input that PWM-dims the lit LEDs.
module led_pattern_gen #(
    parameter int N_LED   = 8,
    parameter int CLK_HZ  = 12090000,
    parameter int STEP_HZ = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [1:0]       speed,
`ifdef LED_PWM_DIM_EN
    input  logic [3:0]       duty,
`endif
    output logic             step_o,
    output logic [N_LED-1:0] LED
);
    localparam int DIV = CLK_HZ / STEP_HZ;
    localparam int CW  = $clog2(DIV);

    typedef enum logic {LEFT, RIGHT} dir_t;

    dir_t             dir, dir_nxt;
    logic [CW-1:0]    div_cnt;
    logic [N_LED-1:0] pat, pat_nxt, lit;
    logic [1:0]       mode_q;
    logic [31:0]      limit;
    logic             restart, step;

    assign limit   = (DIV >> speed) - 1;
    assign restart = mode != mode_q;
    // >= rather than == so a shorter period chosen mid-count fires on the next cycle
    assign step    = en && !restart && (32'(div_cnt) >= limit);

    always_comb begin
        pat_nxt = pat;
        dir_nxt = dir;
        if (restart) begin
            pat_nxt = (mode == 2'd3) ? '1 : N_LED'(1);
            dir_nxt = LEFT;
        end else if (step) begin
            case (mode_q)
                2'd0: pat_nxt = {pat[N_LED-2:0], pat[N_LED-1]};
                2'd1: pat_nxt = {pat[0], pat[N_LED-1:1]};
                2'd2: begin
                    pat_nxt = (dir == LEFT) ? pat << 1 : pat >> 1;
                    // turn around on arrival so an end LED is held for one step only
                    if (dir == LEFT && pat_nxt[N_LED-1])
                        dir_nxt = RIGHT;
                    else if (dir == RIGHT && pat_nxt[0])
                        dir_nxt = LEFT;
                end
                default: pat_nxt = ~pat;
            endcase
        end
    end

`ifdef LED_PWM_DIM_EN
    logic [3:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pwm_cnt <= '0;
        else
            pwm_cnt <= pwm_cnt + 4'd1;
    end

    assign lit = pat_nxt & {N_LED{pwm_cnt < duty}};
`else
    assign lit = pat_nxt;
`endif

    // LED is loaded from the next pattern so its change lands on the same edge as step_o
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            pat     <= N_LED'(1);
            dir     <= LEFT;
            mode_q  <= '0;
            step_o  <= 1'b0;
            LED     <= '1;
        end else begin
            mode_q  <= mode;
            pat     <= pat_nxt;
            dir     <= dir_nxt;
            step_o  <= step;
            LED     <= en ? ~lit : '1;
            if (restart || step)
                div_cnt <= '0;
            else if (en)
                div_cnt <= div_cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: scoreboard bench for led_pattern_gen with an index-based reference model.
module tb_led_pattern_gen;
    localparam int N   = 8;
    localparam int DIV = 16;

    typedef struct packed {
        logic [N-1:0] led;
        logic         step;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'd0;
    logic [1:0]   speed = 2'd0;
    logic         step_o;
    logic [N-1:0] led;

    exp_t q[$];
    exp_t pend;
    exp_t got;
    int   errors = 0;
    int   checks = 0;
    int   m_mode, m_cnt, m_k;

    led_pattern_gen #(.N_LED(N), .CLK_HZ(16), .STEP_HZ(1)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .mode(mode),
        .speed(speed),
        .step_o(step_o),
        .LED(led)
    );

    always #5 clk = ~clk;

    // lit pattern after k steps since the last restart in mode md
    function automatic logic [N-1:0] pat_of(int md, int k);
        int p;
        int idx;
        if (md == 3)
            return (k % 2 == 0) ? '1 : '0;
        p   = (md == 2) ? k % (2 * (N - 1)) : k % N;
        idx = (md == 0) ? p : (md == 1) ? (N - p) % N : (p <= N - 1) ? p : 2 * (N - 1) - p;
        return N'(1) << idx;
    endfunction

    task automatic model_reset();
        m_mode    = 0;
        m_cnt     = 0;
        m_k       = 0;
        pend.led  = '1;
        pend.step = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, req);
        end
    endtask

    // one clock cycle: publish last cycle's expectation, drive inputs, advance the model
    task automatic cyc(input logic e, input logic [1:0] m, input logic [1:0] s);
        logic st;
        st = 1'b0;
        q.push_back(pend);
        en    = e;
        mode  = m;
        speed = s;
        if (int'(m) != m_mode) begin
            m_cnt = 0;
            m_k   = 0;
        end else if (e) begin
            if (m_cnt >= (DIV >> s) - 1) begin
                m_cnt = 0;
                m_k++;
                st = 1'b1;
            end else begin
                m_cnt++;
            end
        end
        m_mode    = int'(m);
        pend.led  = e ? ~pat_of(m_mode, m_k) : '1;
        pend.step = st;
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        check("async_rst_led", led, 32'hFF);
        check("async_rst_step", step_o, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_hold_led", led, 32'hFF);
        rst_n = 1'b1;
        model_reset();
    endtask

    always @(negedge clk) begin
        if (rst_n && q.size() > 0) begin
            got = q.pop_front();
            checks += 2;
            if (led !== got.led) begin
                errors++;
                $display("FAIL led t=%0t got=%h expected=%h", $time, led, got.led);
            end
            if (step_o !== got.step) begin
                errors++;
                $display("FAIL step_o t=%0t got=%b expected=%b", $time, step_o, got.step);
            end
        end
    end

    initial begin
        logic       re;
        logic [1:0] rm, rs;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_led", led, 32'hFF);
        check("reset_step", step_o, 0);
        rst_n = 1'b1;
        repeat (DIV * 9) cyc(1'b1, 2'd0, 2'd0);
        for (int i = 0; i < 200 && pat_of(0, m_k) != 8'h08; i++)
            cyc(1'b1, 2'd0, 2'd0);
        repeat (DIV * 3) cyc(1'b1, 2'd1, 2'd0);
        repeat (DIV * 16) cyc(1'b1, 2'd2, 2'd0);
        cyc(1'b1, 2'd0, 2'd0);
        for (int i = 0; i < 64 && m_cnt != 10; i++)
            cyc(1'b1, 2'd0, 2'd0);
        repeat (20) cyc(1'b1, 2'd0, 2'd2);
        repeat (DIV * 3 + 7) cyc(1'b1, 2'd3, 2'd0);
        repeat (40) cyc(1'b0, 2'd3, 2'd0);
        repeat (DIV * 3) cyc(1'b1, 2'd3, 2'd0);
        cyc(1'b1, 2'd2, 2'd3);
        for (int i = 0; i < 100 && (m_k % 14 < 8 || m_k % 14 > 13); i++)
            cyc(1'b1, 2'd2, 2'd3);
        async_reset();
        repeat (DIV * 3) cyc(1'b1, 2'd2, 2'd0);
        re = 1'b1;
        rm = 2'd0;
        rs = 2'd0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) rm = 2'($urandom);
            if ($urandom_range(0, 59) == 0) re = ~re;
            if ($urandom_range(0, 99) == 0) rs = 2'($urandom);
            cyc(re, rm, rs);
        end
        repeat (2) cyc(1'b1, rm, rs);
        @(negedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
